// File: rtl/c64_bus_pkg.sv
// Shared types and phase constants for the C64 cartridge-port bus initiator.
package c64_bus_pkg;

  typedef enum logic [1:0] {
    SPACE_IO1  = 2'd0,
    SPACE_IO2  = 2'd1,
    SPACE_ROML = 2'd2,
    SPACE_ROMH = 2'd3
  } space_e;

  localparam logic [2:0] PH_STROBE_ON = 3'd1;
  localparam logic [2:0] PH_DATA_ON   = 3'd4;
  localparam logic [2:0] PH_LAST      = 3'd7;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

endpackage

// File: rtl/c64_phi2_gen.sv
// Eight-phase DotClk divider: Ph counter, PHI2 = Ph[2] and a last-phase flag.
module c64_phi2_gen
  import c64_bus_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [2:0] ph_o,
  output logic       ph_last_o,
  output logic       phi2_o
);

  logic [2:0] ph_q;
  logic [2:0] ph_d;

  assign ph_d = ph_q + 3'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q <= 3'd0;
    end else begin
      ph_q <= ph_d;
    end
  end

  assign ph_o      = ph_q;
  assign ph_last_o = (ph_q == PH_LAST);
  assign phi2_o    = ph_q[2];

endmodule

// File: rtl/c64_bus_initiator.sv
// Request/response front end driving one C64 bus cycle per PHI2 period.
// Optional C64_BA_WAIT_EN: hold off acceptance while BA is low at Ph7.
//   state     | meaning
//   ST_IDLE   | no cycle in this window, strobes high
//   ST_ACTIVE | accepted cycle occupies this Ph0..Ph7 window
module c64_bus_initiator
  import c64_bus_pkg::*;
(
  input  logic        DotClk,
  input  logic        RES,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  input  logic [1:0]  req_space,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        PHI2,
  output logic [15:0] A,
  output logic        nWE,
  output logic        nIO1,
  output logic        nIO2,
  output logic        nROML,
  output logic        nROMH,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  input  logic        BA
);

  logic [2:0] ph;
  logic       ph_last;

  c64_phi2_gen u_phi2_gen (
    .clk_i     (DotClk),
    .rst_i     (RES),
    .ph_o      (ph),
    .ph_last_o (ph_last),
    .phi2_o    (PHI2)
  );

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  space_e      space_q, space_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        accept;

`ifdef C64_BA_WAIT_EN
  assign req_ready = ph_last && !RES && BA;
`else
  logic unused_ba;
  assign unused_ba = BA;
  assign req_ready = ph_last && !RES;
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    space_d     = space_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    if (ph_last) begin
      state_d = accept ? ST_ACTIVE : ST_IDLE;
      // completion: read data is sampled on the edge that closes Ph7
      if (state_q == ST_ACTIVE) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 8'h00 : D_in;
      end
    end
    if (accept) begin
      addr_d  = req_addr;
      we_d    = req_we;
      wdata_d = req_wdata;
      space_d = space_e'(req_space);
    end
  end

  always_ff @(posedge DotClk) begin
    if (RES) begin
      state_q     <= ST_IDLE;
      addr_q      <= 16'h0000;
      we_q        <= 1'b0;
      wdata_q     <= 8'h00;
      space_q     <= SPACE_IO1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      space_q     <= space_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  logic strobe_on;
  logic data_on;

  assign strobe_on = (state_q == ST_ACTIVE) && (ph >= PH_STROBE_ON);
  assign data_on   = (state_q == ST_ACTIVE) && we_q && (ph >= PH_DATA_ON);

  assign nIO1  = !(strobe_on && (space_q == SPACE_IO1));
  assign nIO2  = !(strobe_on && (space_q == SPACE_IO2));
  assign nROML = !(strobe_on && (space_q == SPACE_ROML));
  assign nROMH = !(strobe_on && (space_q == SPACE_ROMH));
  assign nWE   = !(strobe_on && we_q);
  assign D_oe  = data_on;
  assign D_out = data_on ? wdata_q : 8'h00;
  assign A     = addr_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
